// File: rtl/harris_response.sv
// Harris corner response over a 6x6 window: Sobel gradients at the 16 interior
// centres, structure-tensor sums, R = det - trace^2/16, five register stages.

module harris_grad (
    input  logic [71:0]        nbhd_i,
    output logic signed [10:0] ix_o,
    output logic signed [10:0] iy_o
);
    logic signed [10:0] p [3][3];

    always_comb begin
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                p[r][c] = $signed({3'b000, nbhd_i[(r*3+c)*8 +: 8]});
    end

    assign ix_o = (p[0][2] - p[0][0]) + ((p[1][2] - p[1][0]) <<< 1) + (p[2][2] - p[2][0]);
    assign iy_o = (p[2][0] - p[0][0]) + ((p[2][1] - p[0][1]) <<< 1) + (p[2][2] - p[0][2]);
endmodule

module harris_response #(
    parameter int                IMG_WIDTH  = 480,
    parameter int                IMG_HEIGHT = 360,
    parameter logic signed [51:0] THRESH    = 52'sd1_000_000_000_000,
    parameter int                BORDER     = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [287:0] window_flat,
    input  logic         window_valid,
    output logic         out_valid,
    output logic [51:0]  response,
    output logic         corner,
    output logic [8:0]   x,
    output logic [8:0]   y,
    output logic         frame_done
);
    localparam int         NPOS  = 16;
    localparam logic [8:0] XLAST = 9'(IMG_WIDTH - 1);
    localparam logic [8:0] YLAST = 9'(IMG_HEIGHT - 1);

    logic [5:1]        vld_pipe_q;
    logic [5:1][8:0]   xp_q, yp_q;
    logic [8:0]        xcnt_q, xcnt_d, ycnt_q, ycnt_d;

    // S1 gradients
    logic [NPOS-1:0][71:0] nbhd;
    logic signed [10:0]    ix_d [NPOS];
    logic signed [10:0]    iy_d [NPOS];
    logic signed [10:0]    ix_q [NPOS];
    logic signed [10:0]    iy_q [NPOS];

    for (genvar i = 0; i < NPOS; i++) begin : g_pos
        for (genvar dr = 0; dr < 3; dr++) begin : g_r
            for (genvar dc = 0; dc < 3; dc++) begin : g_c
                assign nbhd[i][(dr*3+dc)*8 +: 8] =
                    window_flat[(((i/4)+dr)*6 + (i%4)+dc)*8 +: 8];
            end
        end
        harris_grad u_grad (.nbhd_i(nbhd[i]), .ix_o(ix_d[i]), .iy_o(iy_d[i]));
    end

    // S2 products
    logic [20:0]        ixx_d [NPOS], iyy_d [NPOS];
    logic signed [21:0] ixy_d [NPOS];
    logic [20:0]        ixx_q [NPOS], iyy_q [NPOS];
    logic signed [21:0] ixy_q [NPOS];

    always_comb begin
        for (int i = 0; i < NPOS; i++) begin
            ixx_d[i] = 21'(ix_q[i]) * 21'(ix_q[i]);
            iyy_d[i] = 21'(iy_q[i]) * 21'(iy_q[i]);
            ixy_d[i] = 22'(ix_q[i]) * 22'(iy_q[i]);
        end
    end

    // S3 sums
    logic [24:0]        sxx_d, syy_d, sxx_q, syy_q;
    logic signed [25:0] sxy_d, sxy_q;

    always_comb begin
        sxx_d = '0;
        syy_d = '0;
        sxy_d = '0;
        for (int i = 0; i < NPOS; i++) begin
            sxx_d = sxx_d + {4'b0, ixx_q[i]};
            syy_d = syy_d + {4'b0, iyy_q[i]};
            sxy_d = sxy_d + $signed({{4{ixy_q[i][21]}}, ixy_q[i]});
        end
    end

    // S4 det and trace^2; only trace^2 >> 4 is ever needed, so that is what is kept
    logic signed [49:0] det_d, det_q, sxy_e;
    logic [25:0]        trace;
    logic [50:0]        tr2_full;
    logic [46:0]        tr2s_d, tr2s_q;

    always_comb begin
        sxy_e    = $signed({{24{sxy_q[25]}}, sxy_q});
        det_d    = $signed({25'b0, sxx_q}) * $signed({25'b0, syy_q}) - sxy_e * sxy_e;
        trace    = {1'b0, sxx_q} + {1'b0, syy_q};
        tr2_full = {25'b0, trace} * {25'b0, trace};
        tr2s_d   = tr2_full[50:4];
    end

    // S5 response, corner, frame end
    logic signed [51:0] resp_d, resp_q;
    logic               corner_d, corner_q, fd_d, fd_q;

    always_comb begin
        resp_d   = $signed({{2{det_q[49]}}, det_q}) - $signed({5'b0, tr2s_q});
        corner_d = (resp_d > THRESH) && (xp_q[4] >= 9'(BORDER));
        fd_d     = (xp_q[4] == XLAST) && (yp_q[4] == YLAST);
    end

    always_comb begin
        xcnt_d = xcnt_q;
        ycnt_d = ycnt_q;
        if (window_valid) begin
            if (xcnt_q == XLAST) begin
                xcnt_d = '0;
                ycnt_d = (ycnt_q == YLAST) ? '0 : ycnt_q + 9'd1;
            end else begin
                xcnt_d = xcnt_q + 9'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe_q <= '0;
            xcnt_q     <= '0;
            ycnt_q     <= '0;
            xp_q       <= '0;
            yp_q       <= '0;
            for (int i = 0; i < NPOS; i++) begin
                ix_q[i]  <= '0;
                iy_q[i]  <= '0;
                ixx_q[i] <= '0;
                iyy_q[i] <= '0;
                ixy_q[i] <= '0;
            end
            sxx_q    <= '0;
            syy_q    <= '0;
            sxy_q    <= '0;
            det_q    <= '0;
            tr2s_q   <= '0;
            resp_q   <= '0;
            corner_q <= 1'b0;
            fd_q     <= 1'b0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[4:1], window_valid};
            xcnt_q     <= xcnt_d;
            ycnt_q     <= ycnt_d;
            if (window_valid) begin
                xp_q[1] <= xcnt_q;
                yp_q[1] <= ycnt_q;
                for (int i = 0; i < NPOS; i++) begin
                    ix_q[i] <= ix_d[i];
                    iy_q[i] <= iy_d[i];
                end
            end
            if (vld_pipe_q[1]) begin
                for (int i = 0; i < NPOS; i++) begin
                    ixx_q[i] <= ixx_d[i];
                    iyy_q[i] <= iyy_d[i];
                    ixy_q[i] <= ixy_d[i];
                end
            end
            if (vld_pipe_q[2]) begin
                sxx_q <= sxx_d;
                syy_q <= syy_d;
                sxy_q <= sxy_d;
            end
            if (vld_pipe_q[3]) begin
                det_q  <= det_d;
                tr2s_q <= tr2s_d;
            end
            if (vld_pipe_q[4]) begin
                resp_q   <= resp_d;
                corner_q <= corner_d;
                fd_q     <= fd_d;
            end
            for (int k = 2; k <= 5; k++) begin
                if (vld_pipe_q[k-1]) begin
                    xp_q[k] <= xp_q[k-1];
                    yp_q[k] <= yp_q[k-1];
                end
            end
        end
    end

    assign out_valid  = vld_pipe_q[5];
    assign response   = resp_q;
    assign corner     = corner_q & vld_pipe_q[5];
    assign frame_done = fd_q & vld_pipe_q[5];
    assign x          = xp_q[5];
    assign y          = yp_q[5];
endmodule

// File: tb/tb_harris_response.sv
// Directed bench for harris_response: hand-computed responses for flat, edge and
// corner windows, border suppression, reset flush, and a bubbly stream over a small frame.

module tb_harris_response;
    localparam int W  = 20;
    localparam int H  = 6;
    localparam int NW = W * H + 10;
    localparam longint R_FLAT = 64'sd0;
    localparam longint R_EDGE = -64'sd4329728640000;
    localparam longint R_CORN = 64'sd7492460107500;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [287:0] window_flat = '0;
    logic         window_valid = 1'b0;
    logic         out_valid, corner, frame_done;
    logic [51:0]  response;
    logic [8:0]   x, y;

    int checks = 0;
    int failures = 0;

    typedef struct {
        longint r;
        bit     c;
        int     ex;
        int     ey;
        bit     fd;
    } exp_t;

    harris_response #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .reset(reset), .window_flat(window_flat), .window_valid(window_valid),
        .out_valid(out_valid), .response(response), .corner(corner),
        .x(x), .y(y), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [287:0] mkwin(input int pat);
        logic [287:0] w;
        logic [7:0]   v;
        w = '0;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                case (pat)
                    0:       v = 8'd128;
                    1:       v = (c >= 3) ? 8'd255 : 8'd0;
                    default: v = (r >= 3 && c >= 3) ? 8'd255 : 8'd0;
                endcase
                w[(r*6+c)*8 +: 8] = v;
            end
        end
        return w;
    endfunction

    // One window alone; leaves the bench in the cycle where its result is visible.
    task automatic run1(input int pat);
        window_flat  = mkwin(pat);
        window_valid = 1'b1;
        tick();
        window_valid = 1'b0;
        repeat (3) tick();
        chk("lat4_ov", out_valid, 0);
        tick();
        chk("lat5_ov", out_valid, 1);
    endtask

    initial begin
        exp_t e;
        exp_t eq[$];
        bit   vhist [0:2047];
        int   sent, ex, ey, drain, cyc, fdcnt, pat;
        bit   exp_ov;

        #1 reset = 1'b1;
        #1;
        chk("rst_ov", out_valid, 0);
        chk("rst_resp", $signed(response), 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_corner", corner, 0);
        chk("rst_fd", frame_done, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        run1(0);
        chk("flat_resp", $signed(response), R_FLAT);
        chk("flat_corner", corner, 0);
        chk("flat_x", x, 0);
        chk("flat_y", y, 0);

        run1(1);
        chk("edge_resp", $signed(response), R_EDGE);
        chk("edge_corner", corner, 0);
        chk("edge_x", x, 1);
        tick();
        chk("hold_ov", out_valid, 0);
        chk("hold_resp", $signed(response), R_EDGE);
        chk("hold_x", x, 1);

        run1(0);
        chk("fill_x", x, 2);

        run1(2);
        chk("border_resp", $signed(response), R_CORN);
        chk("border_corner", corner, 0);
        chk("border_x", x, 3);

        window_flat  = mkwin(0);
        window_valid = 1'b1;
        repeat (6) tick();
        window_valid = 1'b0;
        repeat (6) tick();

        run1(2);
        chk("corner_resp", $signed(response), R_CORN);
        chk("corner_flag", corner, 1);
        chk("corner_x", x, 10);
        chk("corner_y", y, 0);
        tick();
        chk("after_corner_flag", corner, 0);
        chk("after_resp_hold", $signed(response), R_CORN);

        // Reset with three results in flight
        window_flat  = mkwin(1);
        window_valid = 1'b1;
        repeat (3) tick();
        window_valid = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("async_rst_ov", out_valid, 0);
        chk("async_rst_resp", $signed(response), 0);
        chk("async_rst_x", x, 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("flushed_ov", out_valid, 0);
            tick();
        end
        run1(1);
        chk("post_rst_x", x, 0);
        chk("post_rst_y", y, 0);
        chk("post_rst_resp", $signed(response), R_EDGE);

        // Stream over a full small frame plus a few windows past the wrap
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sent = 0; ex = 0; ey = 0; drain = 0; cyc = 0; fdcnt = 0;
        while ((sent < NW || drain < 6) && cyc < 2000) begin
            exp_ov = (cyc >= 5) ? vhist[cyc-5] : 1'b0;
            chk("s_ov", out_valid, exp_ov);
            if (exp_ov && eq.size() > 0) begin
                e = eq.pop_front();
                chk("s_resp", $signed(response), e.r);
                chk("s_corner", corner, e.c);
                chk("s_x", x, e.ex);
                chk("s_y", y, e.ey);
                chk("s_fd", frame_done, e.fd);
                if (frame_done) fdcnt++;
            end else begin
                chk("s_idle_corner", corner, 0);
                chk("s_idle_fd", frame_done, 0);
            end
            if (sent < NW && $urandom_range(3) != 0) begin
                pat          = sent % 3;
                window_flat  = mkwin(pat);
                window_valid = 1'b1;
                e.r  = (pat == 0) ? R_FLAT : (pat == 1) ? R_EDGE : R_CORN;
                e.c  = (pat == 2) && (ex >= 5);
                e.ex = ex;
                e.ey = ey;
                e.fd = (ex == W - 1) && (ey == H - 1);
                eq.push_back(e);
                if (ex == W - 1) begin
                    ex = 0;
                    ey = (ey == H - 1) ? 0 : ey + 1;
                end else begin
                    ex++;
                end
                sent++;
            end else begin
                window_valid = 1'b0;
                if (sent >= NW) drain++;
            end
            vhist[cyc] = window_valid;
            cyc++;
            tick();
        end
        chk("s_budget", (cyc < 2000) ? 1 : 0, 1);
        chk("s_fd_count", fdcnt, 1);
        chk("s_drained", eq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
